// File: rtl/vga_sync_decoder_if.sv
// vga_sync_decoder_if: sync/blank stream into the decoder and its recovered timing.
// The master drives hs/vs/blank; the slave (decoder) returns coordinates and measurements.
interface vga_sync_decoder_if #(
  parameter int CW = 11
);
  logic          hs;
  logic          vs;
  logic          blank;
  logic [CW-1:0] RxX;
  logic [CW-1:0] RxY;
  logic          pixel_valid;
  logic [CW-1:0] line_len;
  logic [CW-1:0] frame_lines;
  logic [CW-1:0] active_w;
  logic [CW-1:0] active_h;
  logic          locked;
  logic          err;
  logic [15:0]   err_count;

  modport master (
    output hs, vs, blank,
    input  RxX, RxY, pixel_valid, line_len, frame_lines,
    input  active_w, active_h, locked, err, err_count
  );

  modport slave (
    input  hs, vs, blank,
    output RxX, RxY, pixel_valid, line_len, frame_lines,
    output active_w, active_h, locked, err, err_count
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers coordinates, timing measurements and lock from hs/vs/blank.
// Define VGA_SYNC_DEC_ERRCNT_EN to build the saturating violation counter.
module vga_sync_decoder #(
  parameter int LOCK_FRAMES = 2,
  parameter int CW = 11
) (
  input logic Clk,
  input logic Reset,
  vga_sync_decoder_if.slave bus
);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [3:0]    LF_M1 = 4'(LOCK_FRAMES - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  // {hs, vs, blank} sample and its previous value; ev = {hf, vf, bf, br}
  logic [2:0] s1_q, s1_d, s2_q;
  logic [3:0] ev_q, ev_d;
  logic       hf, vf, bf, br, blank2;

  always_comb begin
    s1_d = {bus.hs, bus.vs, bus.blank};
    ev_d = {s2_q[2] & ~s1_q[2], s2_q[1] & ~s1_q[1],
            s2_q[0] & ~s1_q[0], ~s2_q[0] & s1_q[0]};
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1_q <= '1;
      s2_q <= '1;
      ev_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s1_q;
      ev_q <= ev_d;
    end
  end

  assign {hf, vf, bf, br} = ev_q;
  assign blank2 = s2_q[0];

  logic [CW-1:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [CW-1:0]   x_q, x_d, y_q, y_d;
  logic            seen_q, seen_d;
  logic [CW-1:0]   line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic [CW-1:0]   active_w_q, active_w_d, active_h_q, active_h_d;
  logic            pv_q, pv_d, err_q, err_d, have_ref_q, have_ref_d;
  logic [3:0]      match_cnt_q, match_cnt_d, cnt_n;
  logic [4*CW-1:0] ref_q, ref_d, tuple_d;
  state_t          state_q, state_d;

  always_comb begin
    hcnt_d = inc(hcnt_q);
    line_len_d = line_len_q;
    if (hf) begin
      hcnt_d = ONE;
      line_len_d = hcnt_q;
    end
    // a line starting on the vs fall still belongs to the frame it closes
    vcnt_d = hf ? inc(vcnt_q) : vcnt_q;
    frame_lines_d = frame_lines_q;
    if (vf) begin
      vcnt_d = '0;
      frame_lines_d = hf ? inc(vcnt_q) : vcnt_q;
    end
    x_d = x_q;
    if (bf) x_d = '0;
    else if (!blank2) x_d = inc(x_q);
    active_w_d = br ? inc(x_q) : active_w_q;
    y_d = y_q;
    seen_d = seen_q;
    active_h_d = active_h_q;
    if (vf) begin
      active_h_d = seen_q ? inc(y_q) : '0;
      seen_d = 1'b0;
      y_d = '0;
    end
    if (bf) begin
      y_d = (vf || !seen_q) ? '0 : inc(y_q);
      seen_d = 1'b1;
    end
    pv_d = (state_q == LOCKED) & ~blank2;

    tuple_d = {line_len_d, frame_lines_d, active_w_d, active_h_d};
    cnt_n = (have_ref_q && tuple_d == ref_q) ? match_cnt_q + 4'd1 : 4'd0;
    state_d = state_q;
    match_cnt_d = match_cnt_q;
    have_ref_d = have_ref_q;
    ref_d = ref_q;
    err_d = 1'b0;
    unique case (state_q)
      SEARCH: if (vf) begin
        state_d = MEASURE;
        have_ref_d = 1'b0;
        match_cnt_d = '0;
      end
      MEASURE: if (vf) begin
        match_cnt_d = cnt_n;
        have_ref_d = 1'b1;
        ref_d = tuple_d;
        if (cnt_n == LF_M1) state_d = LOCKED;
      end
      LOCKED: if ((hf && hcnt_q != ref_q[4*CW-1 -: CW]) ||
                  (vf && frame_lines_d != ref_q[3*CW-1 -: CW])) begin
        err_d = 1'b1;
        state_d = SEARCH;
        match_cnt_d = '0;
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      x_q <= '0;
      y_q <= '0;
      seen_q <= 1'b0;
      line_len_q <= '0;
      frame_lines_q <= '0;
      active_w_q <= '0;
      active_h_q <= '0;
      pv_q <= 1'b0;
      err_q <= 1'b0;
      have_ref_q <= 1'b0;
      match_cnt_q <= '0;
      ref_q <= '0;
      state_q <= SEARCH;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      x_q <= x_d;
      y_q <= y_d;
      seen_q <= seen_d;
      line_len_q <= line_len_d;
      frame_lines_q <= frame_lines_d;
      active_w_q <= active_w_d;
      active_h_q <= active_h_d;
      pv_q <= pv_d;
      err_q <= err_d;
      have_ref_q <= have_ref_d;
      match_cnt_q <= match_cnt_d;
      ref_q <= ref_d;
      state_q <= state_d;
    end
  end

`ifdef VGA_SYNC_DEC_ERRCNT_EN
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (err_d && !(&err_count_q)) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) err_count_q <= '0;
    else err_count_q <= err_count_d;
  end

  assign bus.err_count = err_count_q;
`else
  assign bus.err_count = 16'h0000;
`endif

  assign bus.RxX = x_q;
  assign bus.RxY = y_q;
  assign bus.pixel_valid = pv_q;
  assign bus.line_len = line_len_q;
  assign bus.frame_lines = frame_lines_q;
  assign bus.active_w = active_w_q;
  assign bus.active_h = active_h_q;
  assign bus.locked = (state_q == LOCKED);
  assign bus.err = err_q;
endmodule
